// File: rtl/id_decode_ctrl_if.sv
// Decode-stage bundle: fetch handshake, immediate-generator link, ID/EX entry toward EX,
// and the hazard/flush inputs. The decoder connects through the slave modport.
interface id_decode_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   if_valid;
    logic                   if_ready;
    logic [31:0]            if_inst;
    logic [31:0]            if_pc;
    logic [2:0]             imm_op;
    logic [31:0]            imm_inst;
    logic [31:0]            imm_in;
    logic                   id_valid;
    logic                   ex_ready;
    logic [31:0]            id_inst;
    logic [31:0]            id_pc;
    logic [31:0]            id_imm;
    logic                   ex_is_load;
    logic [4:0]             ex_rd;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   id_illegal;

    modport master (
        output if_valid, if_inst, if_pc, imm_in, ex_ready, ex_is_load, ex_rd, flush,
        input  if_ready, imm_op, imm_inst, id_valid, id_inst, id_pc, id_imm, stall_cnt, id_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, imm_in, ex_ready, ex_is_load, ex_rd, flush,
        output if_ready, imm_op, imm_inst, id_valid, id_inst, id_pc, id_imm, stall_cnt, id_illegal
    );
endinterface

// File: rtl/id_decode_ctrl.sv
// RV32I decode-stage controller: opcode -> immediate format, one-entry ID/EX register,
// load-use bubbles and flush. Define ID_ILLEGAL_DETECT_EN to flag unsupported opcodes.
module id_decode_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input logic            clk,
    input logic            rst,
    id_decode_ctrl_if.slave bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_NONE_TYPE = 3'd0;
    localparam logic [2:0] IMM_I_TYPE    = 3'd1;
    localparam logic [2:0] IMM_S_TYPE    = 3'd2;
    localparam logic [2:0] IMM_B_TYPE    = 3'd3;
    localparam logic [2:0] IMM_U_TYPE    = 3'd4;
    localparam logic [2:0] IMM_J_TYPE    = 3'd5;

    // Only EMPTY/FULL are ever stored; HAZARD is derived each cycle from the held entry.
    typedef enum logic [1:0] {EMPTY, FULL, HAZARD} state_e;

    state_e                 state_q, state_d, state_cur;
    logic [6:0]             opcode;
    logic [2:0]             imm_op_d;
    logic                   rs1_use_d, rs2_use_d;
    logic                   rs1_use_q, rs2_use_q;
    logic [31:0]            inst_q, pc_q, imm_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   hazard;
    logic                   if_ready_c, id_valid_c, accept;

    assign opcode = bus.if_inst[6:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        imm_op_d  = IMM_NONE_TYPE;
        rs1_use_d = 1'b1;
        rs2_use_d = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_op_d = IMM_I_TYPE;
            OPC_STORE: begin
                imm_op_d  = IMM_S_TYPE;
                rs2_use_d = 1'b1;
            end
            OPC_BRANCH: begin
                imm_op_d  = IMM_B_TYPE;
                rs2_use_d = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_op_d  = IMM_U_TYPE;
                rs1_use_d = 1'b0;
            end
            OPC_JAL: begin
                imm_op_d  = IMM_J_TYPE;
                rs1_use_d = 1'b0;
            end
            OPC_OP: rs2_use_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.imm_op   = imm_op_d;
    assign bus.imm_inst = bus.if_inst;

    assign hazard = (state_q == FULL) && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    ((rs1_use_q && (inst_q[19:15] == bus.ex_rd)) ||
                     (rs2_use_q && (inst_q[24:20] == bus.ex_rd)));

    assign state_cur = (state_q == FULL && hazard) ? HAZARD : state_q;

    // NOTE: asynchronous active-low reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_cur)
            EMPTY:   if (accept) state_d = FULL;
            FULL: begin
                if (accept)            state_d = FULL;
                else if (bus.ex_ready) state_d = EMPTY;
            end
            HAZARD:  state_d = FULL;
            default: state_d = EMPTY;
        endcase
        if (bus.flush) state_d = EMPTY;
    end

    // if_ready is forced low while reset is held, then follows the handshake combinationally.
    always_comb begin
        if_ready_c = rst && !bus.flush &&
                     ((state_cur == EMPTY) || (state_cur == FULL && bus.ex_ready));
        id_valid_c = (state_cur == FULL);
        accept     = bus.if_valid && if_ready_c;
    end

    assign bus.if_ready = if_ready_c;
    assign bus.id_valid = id_valid_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q    <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_use_q <= 1'b0;
            rs2_use_q <= 1'b0;
        end else if (accept) begin
            inst_q    <= bus.if_inst;
            pc_q      <= bus.if_pc;
            imm_q     <= bus.imm_in;
            rs1_use_q <= rs1_use_d;
            rs2_use_q <= rs2_use_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if (state_cur == HAZARD && stall_q != {STALL_CNT_W{1'b1}})
            stall_q <= stall_q + STALL_CNT_W'(1);
    end

    assign bus.id_inst   = inst_q;
    assign bus.id_pc     = pc_q;
    assign bus.id_imm    = imm_q;
    assign bus.stall_cnt = stall_q;

`ifdef ID_ILLEGAL_DETECT_EN
    logic illegal_q;
    logic illegal_d;

    always_comb begin
        illegal_d = !(opcode inside {OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
                                     OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           illegal_q <= 1'b0;
        else if (bus.flush) illegal_q <= 1'b0;
        else if (accept)    illegal_q <= illegal_d;
    end

    assign bus.id_illegal = illegal_q;
`else
    assign bus.id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Bench for id_decode_ctrl: transaction-level model checked every cycle, directed
// literal expectations, then randomized traffic with hazards and flushes.
module tb_id_decode_ctrl;
    localparam int W = 4;
    localparam logic [W-1:0] STALL_MAX = '1;

`ifdef ID_ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam logic [2:0] C_NONE = 3'd0, C_I = 3'd1, C_S = 3'd2, C_B = 3'd3, C_U = 3'd4, C_J = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    id_decode_ctrl_if #(.STALL_CNT_W(W)) bus ();
    id_decode_ctrl #(.STALL_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Format table from the ISA, keyed directly by opcode.
    function automatic logic [2:0] ref_code(input logic [6:0] op);
        case (op)
            7'h03, 7'h13, 7'h67: return C_I;
            7'h23:               return C_S;
            7'h63:               return C_B;
            7'h37, 7'h17:        return C_U;
            7'h6F:               return C_J;
            default:             return C_NONE;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    endfunction

    // Immediate generator standing in for the shared block next to the decoder.
    function automatic logic [31:0] immgen(input logic [2:0] code, input logic [31:0] i);
        case (code)
            C_I:     return {{20{i[31]}}, i[31:20]};
            C_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
            C_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            C_U:     return {i[31:12], 12'h000};
            C_J:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_hazard(input bit valid, input logic [31:0] inst,
                                      input logic ld, input logic [4:0] rd);
        logic [6:0] op;
        bit r1, r2;
        op = inst[6:0];
        r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return valid && ld && (rd != 5'd0) &&
               ((r1 && inst[19:15] == rd) || (r2 && inst[24:20] == rd));
    endfunction

    assign bus.imm_in = immgen(bus.imm_op, bus.imm_inst);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one held entry plus a saturating bubble count.
    bit           m_valid;
    logic [31:0]  m_inst, m_pc, m_imm;
    bit           m_illegal;
    logic [W-1:0] m_stall;
    logic         m_hzd, m_rdy;

    assign m_hzd = ref_hazard(m_valid, m_inst, bus.ex_is_load, bus.ex_rd);
    assign m_rdy = rst && !bus.flush && (!m_valid || (!m_hzd && bus.ex_ready));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid   <= 1'b0;
            m_inst    <= '0;
            m_pc      <= '0;
            m_imm     <= '0;
            m_illegal <= 1'b0;
            m_stall   <= '0;
        end else begin
            if (m_hzd && m_stall != STALL_MAX) m_stall <= m_stall + W'(1);
            if (bus.flush) begin
                m_valid   <= 1'b0;
                m_illegal <= 1'b0;
            end else if (bus.if_valid && m_rdy) begin
                m_valid   <= 1'b1;
                m_inst    <= bus.if_inst;
                m_pc      <= bus.if_pc;
                m_imm     <= immgen(ref_code(bus.if_inst[6:0]), bus.if_inst);
                m_illegal <= ILL_EN && !ref_legal(bus.if_inst[6:0]);
            end else if (m_valid && !m_hzd && bus.ex_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("id_valid",   32'(bus.id_valid),   32'(m_valid && !m_hzd));
        check("if_ready",   32'(bus.if_ready),   32'(m_rdy));
        check("imm_op",     32'(bus.imm_op),     32'(ref_code(bus.if_inst[6:0])));
        check("imm_inst",   bus.imm_inst,        bus.if_inst);
        check("stall_cnt",  32'(bus.stall_cnt),  32'(m_stall));
        check("id_illegal", 32'(bus.id_illegal), 32'(m_illegal));
        if (m_valid) begin
            check("id_inst", bus.id_inst, m_inst);
            check("id_pc",   bus.id_pc,   m_pc);
            check("id_imm",  bus.id_imm,  m_imm);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [0:10];
        logic [31:0] inst;
        ops  = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};
        inst = $urandom;
        inst[6:0]   = ops[$urandom_range(0, 10)];
        inst[19:15] = 5'($urandom_range(0, 3));
        inst[24:20] = 5'($urandom_range(0, 3));
        return inst;
    endfunction

    initial begin
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
        bus.ex_is_load = 1'b0; bus.ex_rd = '0; bus.flush = 1'b0;

        @(negedge clk);
        check("rst id_valid",  32'(bus.id_valid),  32'd0);
        check("rst if_ready",  32'(bus.if_ready),  32'd0);
        check("rst id_inst",   bus.id_inst,        32'h0);
        check("rst id_pc",     bus.id_pc,          32'h0);
        check("rst id_imm",    bus.id_imm,         32'h0);
        check("rst stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rst illegal",   32'(bus.id_illegal), 32'd0);

        tick(); rst = 1'b1; bus.ex_ready = 1'b1;
        bus.if_valid = 1'b1; bus.if_inst = 32'hFFF00093; bus.if_pc = 32'h100;
        @(negedge clk);
        check("addi imm_op",   32'(bus.imm_op),   32'(C_I));
        check("addi if_ready", 32'(bus.if_ready), 32'd1);

        tick(); bus.if_inst = 32'h00112623; bus.if_pc = 32'h104;
        @(negedge clk);
        check("addi id_valid", 32'(bus.id_valid), 32'd1);
        check("addi id_imm",   bus.id_imm,        32'hFFFFFFFF);
        check("addi id_inst",  bus.id_inst,       32'hFFF00093);
        check("sw imm_op",     32'(bus.imm_op),   32'(C_S));

        tick(); bus.if_inst = 32'h008000EF; bus.if_pc = 32'h108;
        @(negedge clk);
        check("sw id_imm",   bus.id_imm,      32'h0000000C);
        check("jal imm_op",  32'(bus.imm_op), 32'(C_J));

        tick(); bus.if_inst = 32'h002081B3; bus.if_pc = 32'h10C;
        @(negedge clk);
        check("jal id_imm", bus.id_imm, 32'h00000008);
        check("jal id_pc",  bus.id_pc,  32'h108);

        tick(); bus.if_valid = 1'b0; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd1;
        @(negedge clk);
        check("hz1 id_valid", 32'(bus.id_valid),  32'd0);
        check("hz1 if_ready", 32'(bus.if_ready),  32'd0);
        check("hz1 stall",    32'(bus.stall_cnt), 32'd0);
        tick();
        @(negedge clk);
        check("hz2 id_valid", 32'(bus.id_valid),  32'd0);
        check("hz2 if_ready", 32'(bus.if_ready),  32'd0);
        check("hz2 stall",    32'(bus.stall_cnt), 32'd1);

        tick(); bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0; bus.ex_ready = 1'b0;
        @(negedge clk);
        check("rel stall",    32'(bus.stall_cnt), 32'd2);
        check("rel id_valid", 32'(bus.id_valid),  32'd1);
        check("rel id_inst",  bus.id_inst,        32'h002081B3);
        check("hold if_ready", 32'(bus.if_ready), 32'd0);

        tick(); bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0;
        @(negedge clk);
        check("rd0 id_valid", 32'(bus.id_valid),  32'd1);
        check("rd0 id_pc",    bus.id_pc,          32'h10C);
        tick();
        @(negedge clk);
        check("rd0 stall",    32'(bus.stall_cnt), 32'd2);
        check("hold id_inst", bus.id_inst,        32'h002081B3);

        tick(); bus.ex_is_load = 1'b0; bus.ex_ready = 1'b1; bus.if_valid = 1'b1;
        bus.if_inst = 32'h123452B7; bus.if_pc = 32'h110;
        tick(); bus.if_valid = 1'b0; bus.ex_ready = 1'b0; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd8;
        @(negedge clk);
        check("lui id_valid", 32'(bus.id_valid), 32'd1);
        check("lui id_imm",   bus.id_imm,        32'h12345000);
        tick();
        @(negedge clk);
        check("lui stall",    32'(bus.stall_cnt), 32'd2);
        check("lui id_valid2", 32'(bus.id_valid), 32'd1);

        tick(); bus.ex_is_load = 1'b0; bus.flush = 1'b1; bus.if_valid = 1'b1;
        bus.if_inst = 32'h00500113; bus.if_pc = 32'h114; bus.ex_ready = 1'b1;
        @(negedge clk);
        check("fl if_ready", 32'(bus.if_ready), 32'd0);
        tick(); bus.flush = 1'b0; bus.if_valid = 1'b0;
        @(negedge clk);
        check("fl id_valid", 32'(bus.id_valid), 32'd0);
        check("fl id_inst",  bus.id_inst,       32'h123452B7);

        tick(); bus.if_valid = 1'b1; bus.if_inst = 32'h00500113; bus.if_pc = 32'h118;
        tick(); bus.if_valid = 1'b0; bus.ex_ready = 1'b0;
        @(negedge clk);
        check("pre-rst id_valid", 32'(bus.id_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst-async id_valid", 32'(bus.id_valid), 32'd0);
        check("rst-async id_inst",  bus.id_inst,       32'h0);
        tick(); rst = 1'b1;
        bus.if_valid = 1'b1; bus.if_inst = 32'h0000007F; bus.if_pc = 32'h11C; bus.ex_ready = 1'b1;
        tick(); bus.if_valid = 1'b0; bus.ex_ready = 1'b0;
        @(negedge clk);
        check("ill id_valid", 32'(bus.id_valid),   32'd1);
        check("ill flag",     32'(bus.id_illegal), 32'(ILL_EN));
        check("ill imm_op",   32'(bus.imm_op),     32'(C_NONE));

        for (int n = 0; n < 3000; n++) begin
            tick();
            bus.if_valid   = ($urandom_range(0, 9) < 7);
            bus.if_inst    = rand_inst();
            bus.if_pc      = $urandom & 32'hFFFFFFFC;
            bus.ex_ready   = ($urandom_range(0, 9) < 7);
            bus.ex_is_load = ($urandom_range(0, 1) == 1);
            bus.ex_rd      = 5'($urandom_range(0, 3));
            bus.flush      = ($urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        check("final stall saturated", 32'(bus.stall_cnt), 32'(STALL_MAX));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_decode_ctrl.md
Name: id_decode_ctrl

Overview:
- Instruction-decode stage controller for the RV32I pipeline.
- Accepts fetched instructions over a valid/ready handshake and decodes the opcode into the immediate-format select for the shared immediate generator.
- Captures the generator result into a one-entry ID/EX holding register and presents it to EX with valid/ready.
- Inserts load-use bubbles and honours branch flush.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_valid  input  1  fetch presents an instruction
- if_ready  output  1  decode can accept this cycle
- if_inst  input  32  fetched instruction word
- if_pc  input  32  PC of if_inst
- imm_op  output  3  immediate format select to the immediate generator (`IMM_*_TYPE codes from Control.svh)
- imm_inst  output  32  instruction word to the immediate generator (equals if_inst)
- imm_in  input  32  immediate generator result (combinational from imm_op/imm_inst)
- id_valid  output  1  ID/EX entry valid toward EX
- ex_ready  input  1  EX accepts the entry this cycle
- id_inst  output  32  held instruction
- id_pc  output  32  held PC
- id_imm  output  32  held immediate
- ex_is_load  input  1  instruction currently in EX is a load
- ex_rd  input  5  destination register of the EX instruction
- flush  input  1  branch/jump taken; kill decode contents
- stall_cnt  output  STALL_CNT_W  count of load-use bubble cycles, saturating
- id_illegal  output  1  held instruction has an unsupported opcode (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - id_valid=0; id_inst, id_pc, id_imm = 0; stall_cnt=0; id_illegal=0; state=EMPTY.
  - The reset value of if_ready is 0. if_ready becomes combinational once rst deasserts.
- Opcode decode (combinational on if_inst[6:0]):
  - 0000011, 0010011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else -> default code
- rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used by OP (0110011), STORE and BRANCH. Use flags are stored alongside the held entry.
- hazard = held entry valid AND ex_is_load AND ex_rd!=0 AND ((rs1 used AND inst[19:15]==ex_rd) OR (rs2 used AND inst[24:20]==ex_rd)).
- States:
  - EMPTY: no entry held.
  - FULL: entry held, no hazard.
  - HAZARD: entry held and hazard=1. Evaluated combinationally each cycle from the registered entry.
- id_valid = FULL (0 in EMPTY and HAZARD, so EX sees a bubble).
- if_ready = !flush AND (EMPTY OR (FULL AND ex_ready)).
- Accept (if_valid AND if_ready):
  - Next edge: id_inst<=if_inst, id_pc<=if_pc, id_imm<=imm_in. The entry is loaded; no idle cycle between back-to-back instructions.
  - Latency is one cycle from accept to id_valid.
- Drain: FULL AND ex_ready AND no accept -> EMPTY next edge.
- HAZARD: entry is held unchanged regardless of ex_ready. stall_cnt increments by 1 per HAZARD cycle and saturates at all-ones. The hazard clears when EX advances.
- flush=1: the next edge empties the entry (id_valid=0), and if_valid is not accepted that cycle. Flush overrides accept, drain and HAZARD. stall_cnt is not cleared by flush.
- Reset asserted mid-operation discards the entry immediately.
- imm_op and imm_inst always reflect the current if_inst, even when nothing is accepted.

Optional Feature:
- Macro ID_ILLEGAL_DETECT_EN.
- Defined: an opcode outside {LOAD, OP-IMM, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP} is still accepted. It sets id_illegal=1, registered with the entry and valid while id_valid=1. id_illegal clears on the next accept or on flush.
- Undefined: id_illegal is tied to 0, and unknown opcodes pass through with the default imm_op.

Test Plan:
- Reset then if_valid=1, if_inst=0xFFF00093 (addi x1,x0,-1), ex_ready=1 -> the next cycle shows id_valid=1, id_imm=0xFFFFFFFF and imm_op=I at accept; then continuous streaming at 1 instruction/cycle.
- Store 0x00112623 (sw x1,12(x2)) -> id_imm=0x0000000C. JAL 0x008000EF -> imm_op=J, id_imm=0x00000008.
- Held add x3,x1,x2 with ex_is_load=1, ex_rd=1 for 2 cycles -> id_valid=0 and if_ready=0 for 2 cycles; stall_cnt goes 0->2; the entry is released after ex_is_load drops.
- The same held add with ex_rd=0, or with LUI held and ex_rd matching inst[19:15] -> no bubble, stall_cnt unchanged.
- flush=1 while FULL and if_valid=1 -> if_ready=0, id_valid=0 the next cycle, and the incoming instruction is not captured; rst pulsed low while FULL -> id_valid=0 immediately.
- ex_ready=0 while FULL -> id_inst, id_pc and id_imm stable and if_ready=0. With ID_ILLEGAL_DETECT_EN, if_inst=0x0000007F -> id_illegal=1; without it -> id_illegal=0.
